// File: rtl/game_round_ctrl_pkg.sv
// Shared game-flow definitions: state codes,
// seconds ceiling and a saturating helper.
package game_round_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM        = 3'd1,
    S_PLAY       = 3'd2,
    S_PAUSED     = 3'd3,
    S_LEVEL_DONE = 3'd4,
    S_WIN        = 3'd5,
    S_LOSE       = 3'd6
  } state_t;

  localparam int MAX_SECS = 999;

  function automatic logic [9:0] sat_secs(input int v);
    if (v > MAX_SECS) return 10'(MAX_SECS);
    return 10'(v);
  endfunction

endpackage

// File: rtl/game_round_ctrl_sec_prescaler.sv
// Game-second prescaler shared by the round
// countdown and the level-done hold timer.
module game_round_ctrl_sec_prescaler #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = run & (cnt == LAST);

  // cycle counter; clear wins over run, wraps at LAST
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: arm, countdown, pause, level advance, win/lose.
// Optional bonus time on kills: GAME_ROUND_BONUS_TIME_EN.
module game_round_ctrl
  import game_round_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int ROUND_SECS  = 60,
  parameter int NUM_ENEMIES = 7,
  parameter int NUM_LEVELS  = 3,
  parameter int HOLD_SECS   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_btn,
  input  logic                   pause_btn,
  input  logic [NUM_ENEMIES-1:0] enemy_dead,
  output logic                   enemy_respawn,
  output logic                   play_en,
  output logic                   tick_1hz,
  output logic [9:0]             seconds_left,
  output logic [1:0]             level,
  output logic [2:0]             state,
  output logic                   game_over,
  output logic                   victory
);

  state_t     state_q, state_d;
  logic [9:0] secs_q, secs_d;
  logic [9:0] secs_dec;
  logic [1:0] level_q, level_d;
  logic [9:0] hold_q, hold_d;
  logic       start_last, pause_last;
  logic       start_edge, pause_edge;
  logic       tick_q, resp_q;
  logic       presc_run, presc_clear;
  logic       sec_tick;
  logic       all_dead;

  assign start_edge = start_btn & ~start_last;
  assign pause_edge = pause_btn & ~pause_last;
  assign all_dead   = &enemy_dead;
  assign secs_dec   = (sec_tick && secs_q != '0) ?
                      secs_q - 10'd1 : secs_q;

`ifdef GAME_ROUND_BONUS_TIME_EN
  logic [NUM_ENEMIES-1:0] dead_last;
  logic [NUM_ENEMIES-1:0] dead_rise;

  assign dead_rise = enemy_dead & ~dead_last;

  // previous enemy flags for per-bit rise detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dead_last <= '0;
    else      dead_last <= enemy_dead;
  end
`endif

  game_round_ctrl_sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (presc_run),
    .clear(presc_clear),
    .tick (sec_tick)
  );

  // button history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_last <= 1'b0;
      pause_last <= 1'b0;
    end else begin
      start_last <= start_btn;
      pause_last <= pause_btn;
    end
  end

  // next state, counters and prescaler control
  always_comb begin
    state_d     = state_q;
    secs_d      = secs_q;
    level_d     = level_q;
    hold_d      = hold_q;
    presc_run   = 1'b0;
    presc_clear = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_ARM;
      end
      S_ARM: begin
        secs_d      = 10'(ROUND_SECS);
        presc_clear = 1'b1;
        state_d     = S_PLAY;
      end
      S_PLAY: begin
        presc_run = 1'b1;
        secs_d    = secs_dec;
`ifdef GAME_ROUND_BONUS_TIME_EN
        secs_d = sat_secs(int'(secs_dec) +
                          2 * $countones(dead_rise));
`endif
        if (all_dead) begin
          state_d     = S_LEVEL_DONE;
          presc_clear = 1'b1;
          hold_d      = 10'(HOLD_SECS);
        end else if (sec_tick && secs_q == 10'd1) begin
          state_d = S_LOSE;
        end else if (pause_edge) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_edge) state_d = S_PLAY;
      end
      S_LEVEL_DONE: begin
        presc_run = 1'b1;
        if (sec_tick) begin
          if (hold_q <= 10'd1) begin
            if (level_q == 2'(NUM_LEVELS - 1)) begin
              state_d = S_WIN;
            end else begin
              level_d = level_q + 2'd1;
              state_d = S_ARM;
            end
          end else begin
            hold_d = hold_q - 10'd1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (start_edge) begin
          level_d = 2'd0;
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, counters and registered pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      secs_q  <= '0;
      level_q <= '0;
      hold_q  <= '0;
      tick_q  <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      tick_q  <= sec_tick;
      resp_q  <= (state_d == S_ARM);
    end
  end

  assign enemy_respawn = resp_q;
  assign tick_1hz      = tick_q;
  assign seconds_left  = secs_q;
  assign level         = level_q;
  assign state         = state_q;
  assign play_en       = (state_q == S_PLAY);
  assign game_over     = (state_q == S_LOSE);
  assign victory       = (state_q == S_WIN);

endmodule
